// File: rtl/pic32_spi_slave.sv
// SPI mode-0 slave bridging the PIC32 link onto a byte-wide register bus,
// with auto-incrementing burst access and a level interrupt line back to the PIC32.
module pic32_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] IRQ_ADDR    = 7'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       sint,
  output logic [6:0] reg_addr,
  output logic       reg_read,
  input  logic [7:0] reg_rdata,
  output logic       reg_write,
  output logic [7:0] reg_wdata,
  input  logic       irq_set
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr, vld_sr;
  logic                   sck_sync, cs_sync, mosi_sync, vld_sync;
  logic                   sck_d, cs_d, armed;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall, frame_abort;

  logic [6:0] rx_sr;
  logic [7:0] rx_byte;
  logic [7:0] tx_sr;
  logic [2:0] bit_cnt;
  logic       rw;
  logic       rd_vld_p1;

  logic byte_done, cmd_done, data_done;
  logic rd_req, wr_req, shift_rx, shift_tx;

  // Stage p0: input synchronisers and edge detection
  // CS resets to inactive and is only trusted once a real high level has been
  // seen, so a frame already running when reset lifts is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sr  <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      vld_sr  <= '0;
      sck_d   <= 1'b0;
      cs_d    <= 1'b1;
      armed   <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      vld_sr  <= {vld_sr[SYNC_STAGES-2:0], 1'b1};
      sck_d   <= sck_sync;
      cs_d    <= cs_sync;
      if (vld_sync && cs_sync)
        armed <= 1'b1;
    end
  end

  assign sck_sync  = sck_sr[SYNC_STAGES-1];
  assign cs_sync   = cs_sr[SYNC_STAGES-1];
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign vld_sync  = vld_sr[SYNC_STAGES-1];

  assign sck_rise    = sck_sync & ~sck_d;
  assign sck_fall    = ~sck_sync & sck_d;
  assign cs_rise     = cs_sync & ~cs_d;
  assign cs_fall     = armed & ~cs_sync & cs_d;
  assign frame_abort = cs_rise | cs_fall;

  assign rx_byte   = {rx_sr, mosi_sync};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && !frame_abort;
  assign cmd_done  = (state == CMD) && byte_done;
  assign data_done = (state == DATA) && byte_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise)
      state_nxt = IDLE;
    else if (cs_fall)
      state_nxt = CMD;
    else if (cmd_done)
      state_nxt = DATA;
  end

  always_comb begin
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    shift_rx    = 1'b0;
    shift_tx    = 1'b0;
    spi_miso    = 1'b0;
    spi_miso_oe = ~cs_sync;
    case (state)
      CMD: begin
        shift_rx = sck_rise && !frame_abort;
        rd_req   = cmd_done && rx_byte[7];
      end
      DATA: begin
        shift_rx = sck_rise && !frame_abort;
        shift_tx = sck_fall && (bit_cnt != 3'd0) && !frame_abort;
        rd_req   = data_done && rw;
        wr_req   = data_done && !rw;
        spi_miso = rw ? tx_sr[7] : 1'b0;
      end
      default: ;
    endcase
  end

  // Stage p1: byte assembly, bus strobes and the read-data return path
  // Read data arrives one clk after reg_read and is captured while still in DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      rd_vld_p1 <= 1'b0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      reg_wdata <= '0;
    end else begin
      reg_read  <= rd_req;
      reg_write <= wr_req;
      rd_vld_p1 <= reg_read;
      if (wr_req)
        reg_wdata <= rx_byte;
      if (frame_abort) begin
        rx_sr   <= '0;
        tx_sr   <= '0;
        bit_cnt <= '0;
        rw      <= 1'b0;
      end else begin
        if (shift_rx) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (cmd_done)
          rw <= rx_byte[7];
        if (rd_vld_p1 && (state == DATA))
          tx_sr <= reg_rdata;
        else if (shift_tx)
          tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  // Reads advance the address before the prefetch strobe; writes advance it after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      reg_addr <= '0;
    else if (cmd_done)
      reg_addr <= rx_byte[6:0];
    else if (data_done && rw)
      reg_addr <= reg_addr + 7'd1;
    else if (reg_write)
      reg_addr <= reg_addr + 7'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sint <= 1'b0;
    else if (irq_set)
      sint <= 1'b1;
    else if (reg_read && (reg_addr == IRQ_ADDR))
      sint <= 1'b0;
  end

endmodule
